// File: rtl/eva_ahb_pkg.sv
// Shared AHB-Lite encodings and the slave state type for the EVA SRAM slave.
// Imported by the lane decoder, the slave top and the testbench.
package eva_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR1,
    ERR2
  } slave_state_e;

endpackage

// File: rtl/eva_ahb_sram_slave_if.sv
// AHB-Lite bus signals between the EVA bus-function master and the SRAM slave.
// Clock and reset stay outside the interface as plain ports.
interface eva_ahb_sram_slave_if;

  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot, hready_in,
    output hready_out, hresp, hrdata
  );

endinterface

// File: rtl/eva_ahb_lane_dec.sv
// Little-endian byte-lane decoder: maps transfer size and low address bits to
// write-lane enables and flags misaligned or unsupported sizes.
module eva_ahb_lane_dec
  import eva_ahb_pkg::*;
(
  input  logic [1:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] lanes,
  output logic       bad
);

  always_comb begin
    lanes = 4'b0000;
    bad   = 1'b0;
    case (hsize)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
        bad   = addr_lo[0];
      end
      HSIZE_WORD: begin
        lanes = 4'b1111;
        bad   = |addr_lo;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/eva_ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-addressed register array with programmable wait
// states and the two-cycle ERROR response for bad addresses or sizes.
module eva_ahb_sram_slave
  import eva_ahb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic                 hclk,
  input  logic                 hrest_n,
  eva_ahb_sram_slave_if.slave  bus
);

  localparam int          IDX_W      = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  slave_state_e     state, state_nxt;
  logic [3:0]       wait_cnt;
  logic             dphase_q;
  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       lanes_q;

  logic [3:0]       lanes;
  logic             size_bad;
  logic [31:0]      offset;
  logic             addr_err;
  logic             accept;
  logic             take;
  logic             done;
  logic             unused_bits;

  logic [31:0]      mem [MEM_WORDS];

  eva_ahb_lane_dec u_lane_dec (
    .hsize   (bus.hsize),
    .addr_lo (bus.haddr[1:0]),
    .lanes   (lanes),
    .bad     (size_bad)
  );

  assign offset   = bus.haddr - ADDR_BASE;
  assign addr_err = (bus.haddr < ADDR_BASE) || ({1'b0, bus.haddr} >= ADDR_LIMIT) || size_bad;
  assign accept   = bus.hsel && bus.htrans[1] && bus.hready_in;
  // New address phases are only taken while this slave is showing hready_out=1.
  assign take     = accept && ((state == IDLE) || (state == ERR2));
  assign done     = dphase_q && (state == IDLE);

  assign unused_bits = ^{bus.hburst, bus.hprot, offset};

  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.hready_out = 1'b1;
    bus.hresp      = HRESP_OKAY;
    bus.hrdata     = 32'h0;
    case (state)
      IDLE, ERR2: begin
        if (state == ERR2) begin
          bus.hresp = HRESP_ERROR;
        end
        if (take) begin
          if (addr_err) begin
            state_nxt = ERR1;
          end else if (WAIT_CYC > 0) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        bus.hready_out = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_nxt = IDLE;
        end
      end
      ERR1: begin
        bus.hready_out = 1'b0;
        bus.hresp      = HRESP_ERROR;
        state_nxt      = ERR2;
      end
      default: state_nxt = IDLE;
    endcase
    if (done && !write_q) begin
      bus.hrdata = mem[idx_q];
    end
  end

  // The commit at the closing edge reads the old captures while a pipelined
  // address phase overwrites them on the same edge.
  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      wait_cnt <= 4'd0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      lanes_q  <= 4'b0000;
    end else begin
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (take) begin
        write_q  <= bus.hwrite;
        idx_q    <= offset[IDX_W+1:2];
        lanes_q  <= lanes;
        dphase_q <= !addr_err;
        wait_cnt <= WAIT_LOAD;
      end else if (done) begin
        dphase_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (done && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) begin
          mem[idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_eva_ahb_sram_slave.sv
// Directed bench for eva_ahb_sram_slave: three instances (0, 3 and 4 wait
// states) share one pipelined AHB driver, and a scoreboard checks each data phase.
module tb_eva_ahb_sram_slave;
  import eva_ahb_pkg::*;

  typedef struct {
    string       tag;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hrest_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  hsize;
  logic [1:0]  cur;

  logic             hready;
  logic [1:0]       hresp;
  logic [31:0]      hrdata;
  logic [2:0]       rdy_v;
  logic [2:0][1:0]  resp_v;
  logic [2:0][31:0] rdata_v;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] pend_wdata;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    eva_ahb_sram_slave_if bus ();
    assign bus.hsel      = hsel && (cur == 2'(g));
    assign bus.htrans    = htrans;
    assign bus.hwrite    = hwrite;
    assign bus.haddr     = haddr;
    assign bus.hwdata    = hwdata;
    assign bus.hsize     = hsize;
    assign bus.hburst    = 3'b000;
    assign bus.hprot     = 4'b0011;
    assign bus.hready_in = hready;
    assign rdy_v[g]      = bus.hready_out;
    assign resp_v[g]     = bus.hresp;
    assign rdata_v[g]    = bus.hrdata;

    eva_ahb_sram_slave #(.WAIT_CYC(g == 0 ? 0 : g + 2)) dut (
      .hclk    (hclk),
      .hrest_n (hrest_n),
      .bus     (bus)
    );
  end

  assign hready = rdy_v[cur];
  assign hresp  = resp_v[cur];
  assign hrdata = rdata_v[cur];

  function automatic exp_t mk(input string tag, input logic [1:0] resp,
                              input logic [31:0] rdata, input int waits);
    exp_t e;
    e.tag   = tag;
    e.resp  = resp;
    e.rdata = rdata;
    e.waits = waits;
    return e;
  endfunction

  function automatic int waits_cur();
    return (cur == 2'd0) ? 0 : int'(cur) + 2;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one address phase while closing the previous data phase, then
  // scores the closed transfer against the head of the queue.
  task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wdata, input exp_t nxt);
    exp_t        e;
    int          lows = 0;
    bit          closed = 1'b0;
    logic [1:0]  resp_s = 2'bxx;
    logic [31:0] rdata_s = 'x;
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = pend_wdata;
    e = (sb.size() > 0) ? sb[0] : mk("idle_start", HRESP_OKAY, 32'h0, 0);
    for (int c = 0; c < 40 && !closed; c++) begin
      @(negedge hclk);
      if (hready === 1'b1) begin
        closed  = 1'b1;
        resp_s  = hresp;
        rdata_s = hrdata;
      end else begin
        lows++;
        check_output($sformatf("%s stall_resp", e.tag), 32'(hresp), 32'(e.resp));
        check_output($sformatf("%s stall_rdata", e.tag), hrdata, 32'h0);
      end
      @(posedge hclk);
      #1;
    end
    check_output($sformatf("%s closed_in_time", e.tag), 32'(closed), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output($sformatf("%s resp", e.tag), 32'(resp_s), 32'(e.resp));
      check_output($sformatf("%s rdata", e.tag), rdata_s, e.rdata);
      check_output($sformatf("%s wait_cycles", e.tag), 32'(lows), 32'(e.waits));
    end
    pend_wdata = wdata;
    sb.push_back(nxt);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input string tag);
    apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b1, a, sz, d, mk(tag, HRESP_OKAY, 32'h0, waits_cur()));
  endtask

  task automatic rd_word(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input string tag);
    apply_stimulus(1'b1, HTRANS_NONSEQ, 1'b0, a, sz, 32'hDEAD_0000, mk(tag, HRESP_OKAY, d, waits_cur()));
  endtask

  task automatic err_access(input logic w, input logic [31:0] a, input logic [1:0] sz,
                            input string tag);
    apply_stimulus(1'b1, HTRANS_NONSEQ, w, a, sz, 32'hFFFF_FFFF, mk(tag, HRESP_ERROR, 32'h0, 1));
  endtask

  task automatic idle_phase(input logic sel, input logic [1:0] trans, input string tag);
    apply_stimulus(sel, trans, 1'b1, 32'h40, HSIZE_WORD, 32'hFFFF_FFFF, mk(tag, HRESP_OKAY, 32'h0, 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hrest_n    = 1'b0;
    cur        = 2'd0;
    hsel       = 1'b0;
    htrans     = HTRANS_IDLE;
    hwrite     = 1'b0;
    haddr      = 32'h0;
    hwdata     = 32'h0;
    hsize      = HSIZE_WORD;
    pend_wdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check_output($sformatf("reset_hready_%0d", g), 32'(rdy_v[g]), 32'd1);
      check_output($sformatf("reset_hresp_%0d", g), 32'(resp_v[g]), 32'd0);
      check_output($sformatf("reset_hrdata_%0d", g), rdata_v[g], 32'h0);
    end
    @(negedge hclk);
    hrest_n = 1'b1;
    @(posedge hclk);
    #1;

    $display("[TB] zero-wait write then pipelined read");
    wr_word(32'h10, HSIZE_WORD, 32'hDEAD_BEEF, "t1_wr");
    rd_word(32'h10, HSIZE_WORD, 32'hDEAD_BEEF, "t1_rd");

    $display("[TB] byte and halfword lane merging");
    wr_word(32'h20, HSIZE_WORD, 32'h1122_3344, "t3_pre");
    wr_word(32'h21, HSIZE_BYTE, 32'h5566_AA77, "t3_byte");
    wr_word(32'h22, HSIZE_HALF, 32'hBBCC_9988, "t3_half");
    rd_word(32'h20, HSIZE_WORD, 32'hBBCC_AA44, "t3_rd");
    apply_stimulus(1'b1, HTRANS_SEQ, 1'b0, 32'h23, HSIZE_BYTE, 32'h0,
                   mk("t3_rd_seq", HRESP_OKAY, 32'hBBCC_AA44, 0));

    $display("[TB] error responses");
    wr_word(32'h0, HSIZE_WORD, 32'hCAFE_F00D, "t4_pre");
    err_access(1'b0, 32'h1000, HSIZE_WORD, "t4_rd_oob");
    err_access(1'b1, 32'h2, HSIZE_WORD, "t4_wr_mis");
    err_access(1'b1, 32'h1, HSIZE_HALF, "t4_half_mis");
    err_access(1'b1, 32'h0, 2'b11, "t4_size11");
    rd_word(32'h0, HSIZE_WORD, 32'hCAFE_F00D, "t4_rd0");
    wr_word(32'hFFC, HSIZE_WORD, 32'h600D_F00D, "t4_last_wr");
    rd_word(32'hFFC, HSIZE_WORD, 32'h600D_F00D, "t4_last_rd");

    $display("[TB] non-accepted address phases");
    wr_word(32'h40, HSIZE_WORD, 32'h0102_0304, "t5_pre");
    idle_phase(1'b1, HTRANS_IDLE, "t5_idle");
    idle_phase(1'b1, HTRANS_BUSY, "t5_busy");
    idle_phase(1'b0, HTRANS_NONSEQ, "t5_nosel");
    rd_word(32'h40, HSIZE_WORD, 32'h0102_0304, "t5_rd");
    idle_phase(1'b0, HTRANS_IDLE, "t5_flush");

    $display("[TB] three wait states");
    cur = 2'd1;
    wr_word(32'h0, HSIZE_WORD, 32'hA5A5_5A5A, "t2_wr");
    rd_word(32'h0, HSIZE_WORD, 32'hA5A5_5A5A, "t2_rd");
    err_access(1'b0, 32'h1000, HSIZE_WORD, "t2_err");
    rd_word(32'h0, HSIZE_WORD, 32'hA5A5_5A5A, "t2_rd_after_err");
    idle_phase(1'b0, HTRANS_IDLE, "t2_flush");

    $display("[TB] reset during wait states");
    cur = 2'd2;
    wr_word(32'h30, HSIZE_WORD, 32'h0BAD_F00D, "t6_pre");
    rd_word(32'h30, HSIZE_WORD, 32'h0BAD_F00D, "t6_rd_pre");
    idle_phase(1'b0, HTRANS_IDLE, "t6_gap");
    wr_word(32'h30, HSIZE_WORD, 32'h1234_5678, "t6_wr");
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = pend_wdata;
    @(negedge hclk);
    check_output("t6_wait_low", 32'(hready), 32'd0);
    @(posedge hclk);
    #2;
    hrest_n = 1'b0;
    #1;
    check_output("t6_rst_hready", 32'(hready), 32'd1);
    check_output("t6_rst_hresp", 32'(hresp), 32'd0);
    check_output("t6_rst_hrdata", hrdata, 32'h0);
    sb.delete();
    pend_wdata = 32'h0;
    @(negedge hclk);
    hrest_n = 1'b1;
    @(posedge hclk);
    #1;
    rd_word(32'h30, HSIZE_WORD, 32'h0BAD_F00D, "t6_rd_post");
    idle_phase(1'b0, HTRANS_IDLE, "t6_flush");
    idle_phase(1'b0, HTRANS_IDLE, "t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eva_ahb_sram_slave.md
Name: eva_ahb_sram_slave

Overview:
AHB-Lite slave on the EVA AHB bus. Sits directly downstream of the EVA AHB bus-function master and consumes the transfers it drives.
Provides a word-addressed register-array memory with a programmable number of wait states. Issues the two-cycle ERROR response for out-of-range, misaligned or unsupported-size accesses.
The bench uses it as the default AHB target for read/write checking.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of memory word 0; must be 4-byte aligned
MEM_WORDS, 1024, memory depth in 32-bit words; power of two, 16..65536
WAIT_CYC, 0, wait states inserted in every OKAY data phase; range 0..15

Ports:
hclk  in  1  bus clock; all state updates on the rising edge
hrest_n  in  1  asynchronous, active-low reset
hsel  in  1  slave select, sampled in the address phase
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 = write
haddr  in  32  byte address
hwdata  in  32  write data, valid in the data phase
hsize  in  2  00 byte, 01 halfword, 10 word, 11 unsupported
hburst  in  3  ignored; each beat is treated independently
hprot  in  4  ignored
hready_in  in  1  bus HREADY; the address phase is accepted only when this is 1
hready_out  out  1  slave HREADYOUT
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  32  read data

Behaviour:
- Reset (hrest_n=0, asynchronous): state IDLE, hready_out=1, hresp=00, hrdata=0, all captured address-phase registers cleared. Memory contents are not reset.
- Reset asserted mid-transfer aborts that transfer. A pending write is not committed. After release the slave is in IDLE with hready_out=1.
- Accept condition: hsel & htrans[1] & hready_in. On acceptance, capture hwrite, the word index (haddr-ADDR_BASE)>>2, the byte lanes and the error flag.
- When not accepted (IDLE/BUSY, not selected, or hready_in=0): no state change. The next cycle shows hready_out=1, hresp=OKAY.
- Error flag is set if any of the following holds:
  - haddr < ADDR_BASE
  - haddr >= ADDR_BASE + 4*MEM_WORDS
  - hsize=11
  - hsize=01 with haddr[0]=1
  - hsize=10 with haddr[1:0]!=00
- Byte lanes (little-endian):
  - byte: lane haddr[1:0]
  - halfword: lanes {haddr[1],0} and {haddr[1],1}
  - word: all 4 lanes
- State machine: IDLE, WAIT, ERR1, ERR2.
  - IDLE -> accepted with error: ERR1.
  - IDLE -> accepted, no error, WAIT_CYC>0: WAIT. The wait counter loads WAIT_CYC-1.
  - IDLE -> accepted, no error, WAIT_CYC=0: IDLE. This is a zero-wait data phase.
  - WAIT: hready_out=0, hresp=OKAY. The counter decrements each cycle. When it reaches 0, the state returns to IDLE; that cycle is the final data-phase cycle.
  - ERR1: hready_out=0, hresp=01. Always goes to ERR2.
  - ERR2: hready_out=1, hresp=01. Then IDLE. A new address phase accepted during ERR2 is processed normally.
- Final data-phase cycle = the cycle with hready_out=1 that closes the transfer.
  - Write: enabled lanes of hwdata are written to mem[index] at the closing edge.
  - Read: hrdata = mem[index] combinationally in that cycle. All other cycles drive hrdata=0.
  - Errored transfers never write and return hrdata=0.
- Back-to-back (pipelined) transfers: the next address phase is accepted in the final data-phase cycle of the current one. The current index and lanes must be used for the commit before they are overwritten.
- Read immediately after a write to the same word returns the newly written data; no bypass is needed because the commit edge precedes the read data phase.
- Address wrap: only the computed index is used. There is no aliasing beyond MEM_WORDS; those accesses raise the error flag.
- Latency: read data appears WAIT_CYC+1 cycles after the accepted address-phase edge.

Decomposition:
- Package eva_ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - HSIZE_BYTE/HALF/WORD
  - slave state enum {IDLE, WAIT, ERR1, ERR2}
- One sub-module, eva_ahb_lane_dec: combinational (hsize, haddr[1:0]) -> 4-bit byte-lane enable plus misalign/unsupported flag.

Test Plan:
1. WAIT_CYC=0: NONSEQ write word 32'hDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back -> read data phase hready_out=1, hresp=00, hrdata=32'hDEADBEEF.
2. WAIT_CYC=3: read @0x0 -> hready_out low exactly 3 cycles, then high with hrdata; write is committed only at the closing edge.
3. Preload word 0x20 with 0x11223344. Write byte 0xAA @0x21, then write halfword 0xBBCC @0x22 -> read @0x20 returns 0xBBCCAA44.
4. Read @ADDR_BASE+4*MEM_WORDS; write word @0x2 -> each gives a two-cycle ERROR (hready_out 0 then 1, hresp=01), memory unchanged, hrdata=0.
5. htrans=IDLE or BUSY, or hsel=0 with NONSEQ -> hready_out stays 1, hresp=00, no memory change.
6. Assert hrest_n low during the WAIT of a write @0x30 (WAIT_CYC=4) -> outputs return to reset values immediately, and word 0x30 keeps its old value.
